// File: rtl/decode_stage_if.sv
// decode_stage_if: the two handshake boundaries of the decode stage.
//   in_valid/in_ready/in_instr  - fetch side (fetch drives valid/instr, stage drives ready)
//   out_valid/out_ready         - regfile side (stage drives valid, consumer drives ready)
//   opcode, rd, rs, rt, shamt, aluop, imm_sext, target, itype - decoded fields
// Modports: slave = the decode stage itself; master = the fetch + consumer environment.
interface decode_stage_if #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned OPC_W   = 5,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned DATA_W  = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic [INSTR_W-1:0]       in_instr;
    logic                     out_valid;
    logic                     out_ready;
    logic [OPC_W-1:0]         opcode;
    logic [REG_W-1:0]         rd;
    logic [REG_W-1:0]         rs;
    logic [REG_W-1:0]         rt;
    logic [REG_W-1:0]         shamt;
    logic [REG_W-1:0]         aluop;
    logic [DATA_W-1:0]        imm_sext;
    logic [INSTR_W-OPC_W-1:0] target;
    logic [1:0]               itype;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, opcode, rd, rs, rt, shamt, aluop, imm_sext, target, itype
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, opcode, rd, rs, rt, shamt, aluop, imm_sext, target, itype
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage between fetch and regfile read.
// Holds up to two instructions (OUT register plus one SKID register) so fetch can keep
// streaming at one instruction per cycle while the consumer stalls.
// Ports:
//   clock    - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   flush    - discard everything held and the instruction offered this cycle
//   dec_io   - decode_stage_if.slave: fetch handshake in, decoded fields + handshake out
module decode_stage #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned OPC_W   = 5,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned IMM_W   = 17,
    parameter int unsigned DATA_W  = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          flush,
    decode_stage_if.slave dec_io
);
    typedef enum logic [1:0] {
        ItypeR   = 2'd0,
        ItypeI   = 2'd1,
        ItypeJi  = 2'd2,
        ItypeJii = 2'd3
    } itype_e;

    localparam int unsigned RdHi = INSTR_W - OPC_W - 1;
    localparam int unsigned RsHi = RdHi - REG_W;
    localparam int unsigned RtHi = RsHi - REG_W;
    localparam int unsigned ShHi = RtHi - REG_W;
    localparam int unsigned AoHi = ShHi - REG_W;

    localparam logic [OPC_W-1:0] OpcR    = OPC_W'(5'b00000);
    localparam logic [OPC_W-1:0] OpcJ    = OPC_W'(5'b00001);
    localparam logic [OPC_W-1:0] OpcJal  = OPC_W'(5'b00011);
    localparam logic [OPC_W-1:0] OpcJr   = OPC_W'(5'b00100);
    localparam logic [OPC_W-1:0] OpcSetx = OPC_W'(5'b10101);
    localparam logic [OPC_W-1:0] OpcBex  = OPC_W'(5'b10110);

    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic               skid_valid_q, skid_valid_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic               accept;
    logic               emit;
    logic [OPC_W-1:0]   opcode;
    itype_e             itype;

    // in_ready comes straight from the SKID flag, so out_ready never reaches it combinationally.
    assign accept = dec_io.in_valid && !skid_valid_q;
    assign emit   = out_valid_q && dec_io.out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        if (flush) begin
            // An emit in this cycle has already completed; everything else is dropped.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || emit) begin
            if (skid_valid_q) begin
                // in_ready was low, so no accept can coincide with the skid drain.
                out_valid_d  = 1'b1;
                out_instr_d  = skid_instr_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_instr_d = dec_io.in_instr;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_instr_d = dec_io.in_instr;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_instr_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
        end
    end

    // Decoding is pure slicing of the held instruction; a zeroed register decodes to all-zero
    // fields with itype R, which gives the required reset view.
    assign opcode = out_instr_q[INSTR_W-1 -: OPC_W];

    always_comb begin
        itype = ItypeI;
        case (opcode)
            OpcR:                         itype = ItypeR;
            OpcJ, OpcJal, OpcSetx, OpcBex: itype = ItypeJi;
            OpcJr:                        itype = ItypeJii;
            default:                      itype = ItypeI;
        endcase
    end

    assign dec_io.in_ready  = !skid_valid_q;
    assign dec_io.out_valid = out_valid_q;
    assign dec_io.opcode    = opcode;
    assign dec_io.rd        = out_instr_q[RdHi -: REG_W];
    assign dec_io.rs        = out_instr_q[RsHi -: REG_W];
    assign dec_io.rt        = out_instr_q[RtHi -: REG_W];
    assign dec_io.shamt     = out_instr_q[ShHi -: REG_W];
    assign dec_io.aluop     = out_instr_q[AoHi -: REG_W];
    assign dec_io.imm_sext  = DATA_W'($signed(out_instr_q[IMM_W-1:0]));
    assign dec_io.target    = out_instr_q[INSTR_W-OPC_W-1:0];
    assign dec_io.itype     = itype;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed literal checks plus a randomized run compared every cycle
// against a queue-based model of the decode stage.
module tb_decode_stage;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic flush   = 1'b0;

    decode_stage_if dif ();

    decode_stage dut (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .dec_io  (dif)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [31:0] opcode, rd, rs, rt, shamt, aluop, imm, target, itype;
    } exp_t;

    // Instructions accepted but not yet delivered, oldest first.
    logic [31:0] mq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t decode_ref(input logic [31:0] w);
        exp_t e;
        int   s;
        e.opcode = (w >> 27) & 32'h1f;
        e.rd     = (w >> 22) & 32'h1f;
        e.rs     = (w >> 17) & 32'h1f;
        e.rt     = (w >> 12) & 32'h1f;
        e.shamt  = (w >> 7) & 32'h1f;
        e.aluop  = (w >> 2) & 32'h1f;
        s = int'(w & 32'h1ffff);
        if (s >= 65536) s = s - 131072;
        e.imm    = 32'(s);
        e.target = w & 32'h7ffffff;
        case (e.opcode)
            32'd0:                    e.itype = 32'd0;
            32'd1, 32'd3, 32'd21, 32'd22: e.itype = 32'd2;
            32'd4:                    e.itype = 32'd3;
            default:                  e.itype = 32'd1;
        endcase
        return e;
    endfunction

    // Compare process: checks DUT against the model, then advances the model for the next edge.
    logic        stall_prev = 1'b0;
    logic [31:0] prev_hdr, prev_imm, prev_tgt;
    always @(negedge clock) begin
        if (!reset_n) begin
            mq.delete();
            stall_prev = 1'b0;
        end else begin
            logic        acc, emt;
            logic [31:0] hdr;
            exp_t        e;
            hdr = 32'({dif.opcode, dif.rd, dif.rs, dif.rt, dif.shamt, dif.aluop});
            check("out_valid", 32'(dif.out_valid), 32'(mq.size() > 0));
            check("in_ready", 32'(dif.in_ready), 32'(mq.size() < 2));
            if (mq.size() > 0) begin
                e = decode_ref(mq[0]);
                check("opcode", 32'(dif.opcode), e.opcode);
                check("rd", 32'(dif.rd), e.rd);
                check("rs", 32'(dif.rs), e.rs);
                check("rt", 32'(dif.rt), e.rt);
                check("shamt", 32'(dif.shamt), e.shamt);
                check("aluop", 32'(dif.aluop), e.aluop);
                check("imm_sext", dif.imm_sext, e.imm);
                check("target", 32'(dif.target), e.target);
                check("itype", 32'(dif.itype), e.itype);
            end
            if (stall_prev) begin
                check("stable_hdr", hdr, prev_hdr);
                check("stable_imm", dif.imm_sext, prev_imm);
                check("stable_tgt", 32'(dif.target), prev_tgt);
            end
            acc = dif.in_valid && (mq.size() < 2);
            emt = (mq.size() > 0) && dif.out_ready;
            if (emt) void'(mq.pop_front());
            if (flush) mq.delete();
            else if (acc) mq.push_back(dif.in_instr);
            stall_prev = dif.out_valid && !dif.out_ready && !flush;
            prev_hdr   = hdr;
            prev_imm   = dif.imm_sext;
            prev_tgt   = 32'(dif.target);
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [4:0] opc_tbl [7];
    initial begin
        opc_tbl[0] = 5'd0;  opc_tbl[1] = 5'd1;  opc_tbl[2] = 5'd3;  opc_tbl[3] = 5'd4;
        opc_tbl[4] = 5'd21; opc_tbl[5] = 5'd22; opc_tbl[6] = 5'd5;

        dif.in_valid  = 1'b0;
        dif.in_instr  = '0;
        dif.out_ready = 1'b0;
        repeat (2) cyc();
        check("rst.out_valid", 32'(dif.out_valid), 32'd0);
        check("rst.in_ready", 32'(dif.in_ready), 32'd1);
        check("rst.opcode", 32'(dif.opcode), 32'd0);
        check("rst.imm", dif.imm_sext, 32'd0);
        check("rst.itype", 32'(dif.itype), 32'd0);
        reset_n = 1'b1;
        cyc();

        // addi
        dif.out_ready = 1'b1;
        dif.in_valid  = 1'b1;
        dif.in_instr  = 32'h2845FFFF;
        cyc();
        dif.in_valid = 1'b0;
        check("addi.valid", 32'(dif.out_valid), 32'd1);
        check("addi.opcode", 32'(dif.opcode), 32'h05);
        check("addi.rd", 32'(dif.rd), 32'd1);
        check("addi.rs", 32'(dif.rs), 32'd2);
        check("addi.imm", dif.imm_sext, 32'hFFFFFFFF);
        check("addi.itype", 32'(dif.itype), 32'd1);
        cyc();

        // add then jal back to back
        dif.in_valid = 1'b1;
        dif.in_instr = 32'h00C22000;
        cyc();
        dif.in_instr = 32'h18000064;
        check("add.rd", 32'(dif.rd), 32'd3);
        check("add.rs", 32'(dif.rs), 32'd1);
        check("add.rt", 32'(dif.rt), 32'd2);
        check("add.shamt", 32'(dif.shamt), 32'd0);
        check("add.aluop", 32'(dif.aluop), 32'd0);
        check("add.itype", 32'(dif.itype), 32'd0);
        cyc();
        dif.in_valid = 1'b0;
        check("jal.valid", 32'(dif.out_valid), 32'd1);
        check("jal.opcode", 32'(dif.opcode), 32'h03);
        check("jal.target", 32'(dif.target), 32'h64);
        check("jal.itype", 32'(dif.itype), 32'd2);
        repeat (2) cyc();

        // Stall: A to OUT, B to SKID, C waits
        dif.out_ready = 1'b0;
        dif.in_valid  = 1'b1;
        dif.in_instr  = 32'h08001234;
        cyc();
        dif.in_instr = 32'h10005678;
        cyc();
        dif.in_instr = 32'h20009ABC;
        repeat (2) cyc();
        check("stall.valid", 32'(dif.out_valid), 32'd1);
        check("stall.in_ready", 32'(dif.in_ready), 32'd0);
        check("stall.A.imm", dif.imm_sext, 32'h00001234);
        check("stall.A.itype", 32'(dif.itype), 32'd2);
        dif.out_ready = 1'b1;
        cyc();
        check("drain.B.imm", dif.imm_sext, 32'h00005678);
        check("drain.in_ready", 32'(dif.in_ready), 32'd1);
        cyc();
        dif.in_valid = 1'b0;
        check("drain.C.imm", dif.imm_sext, 32'h00009ABC);
        check("drain.C.valid", 32'(dif.out_valid), 32'd1);
        cyc();
        check("drain.empty", 32'(dif.out_valid), 32'd0);

        // Flush with occupancy 2 and D offered
        dif.out_ready = 1'b0;
        dif.in_valid  = 1'b1;
        dif.in_instr  = 32'h30000001;
        cyc();
        dif.in_instr = 32'h30000002;
        cyc();
        check("flush.pre_in_ready", 32'(dif.in_ready), 32'd0);
        flush        = 1'b1;
        dif.in_instr = 32'hDEADBEEF;
        cyc();
        flush        = 1'b0;
        dif.in_valid = 1'b0;
        check("flush.out_valid", 32'(dif.out_valid), 32'd0);
        check("flush.in_ready", 32'(dif.in_ready), 32'd1);
        dif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("flush.no_D", 32'(dif.out_valid), 32'd0);
        end

        // Async reset mid-stream
        dif.out_ready = 1'b0;
        dif.in_valid  = 1'b1;
        dif.in_instr  = 32'h2845FFFF;
        cyc();
        dif.in_valid = 1'b0;
        check("midrst.pre_valid", 32'(dif.out_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst.out_valid", 32'(dif.out_valid), 32'd0);
        check("midrst.in_ready", 32'(dif.in_ready), 32'd1);
        check("midrst.opcode", 32'(dif.opcode), 32'd0);
        check("midrst.rd", 32'(dif.rd), 32'd0);
        check("midrst.imm", dif.imm_sext, 32'd0);
        check("midrst.target", 32'(dif.target), 32'd0);
        check("midrst.itype", 32'(dif.itype), 32'd0);
        cyc();
        reset_n = 1'b1;
        cyc();

        // Randomized traffic
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(1, 0) == 1) w[31:27] = opc_tbl[$urandom_range(6, 0)];
            dif.in_instr  = w;
            dif.in_valid  = ($urandom_range(3, 0) != 0);
            dif.out_ready = ($urandom_range(2, 0) != 0);
            flush         = ($urandom_range(49, 0) == 0);
            cyc();
        end
        flush         = 1'b0;
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b1;
        repeat (4) cyc();
        check("end.empty", 32'(dif.out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
